// File: rtl/bus_pkg.sv
// Shared types and constants for the memory/IO bus arbiter.
// Pure declarations: no logic, no latency, no flow control.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM_D,
    MEM_I,
    IO_D,
    ERR_I
  } bus_state_t;

  typedef enum logic [1:0] {
    RD,
    WR,
    FETCH
  } req_type_t;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FFF0;

  function automatic logic in_io(input logic [31:0] addr, input logic [31:0] base);
    return addr >= base;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state counter with terminal count at TIMEOUT-1; tc is combinational from the count.
// Clear has priority over enable; the count parks at terminal count until cleared.
module bus_timeout_ctr
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store onto one memory port, diverting data accesses >= IO_BASE to IO.
// Memory: grant cycle + 1 cycle per wait state, aborted at TIMEOUT; IO and fetch errors take 2 cycles.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int          TIMEOUT      = 16,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic        io_read,
  output logic        io_write,
  input  logic [31:0] io_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);

  bus_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic          d_req, fetch_win, data_win, in_mem, tc, g_io;
  logic [31:0]   g_addr;
  req_type_t     g_type;

  assign d_req     = d_read | d_write;
  assign fetch_win = i_req && (!d_req || starve_cnt == SW'(STARVE_LIMIT));
  assign data_win  = d_req && !fetch_win;
  assign g_type    = fetch_win ? FETCH : (d_write ? WR : RD);
  assign g_addr    = fetch_win ? i_addr : d_addr;
  assign g_io      = in_io(g_addr, IO_BASE);
  assign in_mem    = (state == MEM_D) || (state == MEM_I);

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (!in_mem),
    .en  (in_mem),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      io_addr    <= '0;
      io_wdata   <= '0;
      io_read    <= 1'b0;
      io_write   <= 1'b0;
    end else begin
      io_read  <= 1'b0;
      io_write <= 1'b0;

      // Starvation count only advances while fetch is actually being passed over
      if (!i_req || (state == IDLE && fetch_win)) begin
        starve_cnt <= '0;
      end else if (state == IDLE && data_win && starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (fetch_win || data_win) begin
            if (g_io && g_type == FETCH) begin
              state <= ERR_I;
            end else if (g_io) begin
              state    <= IO_D;
              io_addr  <= d_addr;
              io_wdata <= d_wdata;
              io_read  <= (g_type == RD);
              io_write <= (g_type == WR);
            end else begin
              state     <= (g_type == FETCH) ? MEM_I : MEM_D;
              mem_addr  <= g_addr;
              mem_read  <= (g_type != WR);
              mem_write <= (g_type == WR);
              if (g_type == WR) mem_wdata <= d_wdata;
            end
          end
        end
        MEM_D, MEM_I: begin
          if (mem_ack || tc) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is combinational so ack and done share a cycle
  always_comb begin
    i_done  = 1'b0;
    i_err   = 1'b0;
    i_rdata = '0;
    d_done  = 1'b0;
    d_err   = 1'b0;
    d_rdata = '0;
    case (state)
      MEM_I: begin
        i_done = mem_ack || tc;
        i_err  = !mem_ack && tc;
        if (mem_ack) i_rdata = mem_rdata;
      end
      MEM_D: begin
        d_done = mem_ack || tc;
        d_err  = !mem_ack && tc;
        if (mem_ack) d_rdata = mem_rdata;
      end
      IO_D: begin
        d_done = 1'b1;
        if (io_read) d_rdata = io_rdata;
      end
      ERR_I: begin
        i_done = 1'b1;
        i_err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus random transactions against a transaction-level memory model.
module tb_mem_bus_arbiter;
  localparam int          TIMEOUT = 16;
  localparam int          STARVE  = 4;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0, rst = 1'b0;
  logic        i_req = 1'b0, i_done, i_err;
  logic [31:0] i_addr = '0, i_rdata;
  logic        d_read = 1'b0, d_write = 1'b0, d_done, d_err;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        mem_read, mem_write, mem_ack = 1'b0;
  logic [31:0] io_addr, io_wdata, io_rdata = '0;
  logic        io_read, io_write;

  int tests = 0, fails = 0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_read(io_read), .io_write(io_write),
    .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, {24'd0, mem_read, mem_write, io_read, io_write,
                            i_done, d_done, i_err, d_err}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_io_addr"}, io_addr, 0);
    chk({tag, "_io_wdata"}, io_wdata, 0);
    chk({tag, "_rdata"}, i_rdata | d_rdata, 0);
  endtask

  // One memory access; ack_at = MEM cycle carrying the ack, out of range = never
  task automatic mem_xact(input bit fetch, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at, input bit stray);
    bit tmo;
    int exp_cyc;
    logic [31:0] exp_rd;
    tmo = !(ack_at >= 1 && ack_at <= TIMEOUT);
    exp_cyc = tmo ? TIMEOUT : ack_at;
    exp_rd = (tmo || wr) ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr));
    @(negedge clk);
    mem_ack = 1'b0;
    if (fetch) begin i_req = 1'b1; i_addr = addr; end
    else begin d_read = !wr; d_write = wr; d_addr = addr; d_wdata = wdata; end
    #1 chk("grant_cycle_done", 32'(i_done | d_done), 0);
    for (int c = 1; c <= exp_cyc; c++) begin
      @(negedge clk);
      mem_ack = (c == ack_at);
      mem_rdata = mem_write ? 32'h0 :
                  (slave_mem.exists(mem_addr) ? slave_mem[mem_addr] : init_val(mem_addr));
      if (mem_ack && mem_write) slave_mem[mem_addr] = mem_wdata;
      #1;
      chk("mem_strobes", {30'd0, mem_read, mem_write}, {30'd0, !wr, wr});
      chk("mem_addr", mem_addr, addr);
      if (wr) chk("mem_wdata", mem_wdata, wdata);
      chk("done", 32'(fetch ? i_done : d_done), 32'(c == exp_cyc));
      chk("other_done", 32'(fetch ? d_done : i_done), 0);
    end
    chk("err", 32'(fetch ? i_err : d_err), 32'(tmo));
    chk("rdata", fetch ? i_rdata : d_rdata, exp_rd);
    if (wr && !tmo) ref_mem[addr] = wdata;
    for (int p = 1; p <= 2; p++) begin
      @(negedge clk);
      i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      mem_ack = stray && (p == 2);
      #1;
      chk("post_strobes", {30'd0, mem_read, mem_write}, 0);
      chk("post_done", 32'(i_done | d_done), 0);
    end
  endtask

  task automatic io_xact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] iod);
    @(negedge clk);
    d_read = !wr; d_write = wr; d_addr = addr; d_wdata = wdata; io_rdata = iod; mem_ack = 1'b0;
    #1 chk("io_idle_strobes", {30'd0, io_read, io_write}, 0);
    @(negedge clk);
    #1;
    chk("io_strobes", {30'd0, io_read, io_write}, {30'd0, !wr, wr});
    chk("io_addr", io_addr, addr);
    if (wr) chk("io_wdata", io_wdata, wdata);
    chk("io_done", 32'(d_done), 1);
    chk("io_err", 32'(d_err), 0);
    chk("io_rdata", d_rdata, wr ? 32'h0 : iod);
    chk("io_no_mem", {30'd0, mem_read, mem_write}, 0);
    @(negedge clk);
    d_read = 1'b0; d_write = 1'b0;
    #1;
    chk("io_post_strobes", {30'd0, io_read, io_write}, 0);
    chk("io_post_done", 32'(d_done), 0);
  endtask

  task automatic fetch_io(input logic [31:0] addr);
    @(negedge clk);
    i_req = 1'b1; i_addr = addr; mem_ack = 1'b0;
    #1 chk("ferr_c1_done", 32'(i_done), 0);
    @(negedge clk);
    #1;
    chk("ferr_done", 32'(i_done), 1);
    chk("ferr_err", 32'(i_err), 1);
    chk("ferr_rdata", i_rdata, 0);
    chk("ferr_strobes", {28'd0, mem_read, mem_write, io_read, io_write}, 0);
    @(negedge clk);
    i_req = 1'b0;
    #1;
    chk("ferr_post_done", 32'(i_done), 0);
    chk("ferr_post_strobes", {28'd0, mem_read, mem_write, io_read, io_write}, 0);
  endtask

  initial begin
    int exp_seq[$];
    int n, idone_cyc, kind, ack;
    logic [31:0] ma, ia;

    #1 rst = 1'b1;
    #1 chk_zero("reset");

    // Fetch and data contend from reset release; data always re-requests
    i_req = 1'b1; i_addr = 32'h300; d_read = 1'b1; d_addr = 32'h200;
    for (int k = 0; k < STARVE; k++) exp_seq.push_back(0);
    exp_seq.push_back(1);
    exp_seq.push_back(0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("starve_c1_done", 32'(i_done | d_done), 0);
    n = 0; idone_cyc = 0;
    for (int cyc = 2; cyc <= 30 && n < 6; cyc++) begin
      @(negedge clk);
      mem_ack = mem_read;
      mem_rdata = 32'hC0DE_0000 + 32'(cyc);
      #1;
      if (d_done || i_done) begin
        chk("starve_order", 32'(i_done), 32'(exp_seq[n]));
        chk("starve_addr", mem_addr, i_done ? 32'h300 : 32'h200);
        chk("starve_rdata", i_done ? i_rdata : d_rdata, 32'hC0DE_0000 + 32'(cyc));
        if (i_done && idone_cyc == 0) idone_cyc = cyc;
        n++;
      end
    end
    chk("starve_events", 32'(n), 6);
    chk("starve_idone_cycle", 32'(idone_cyc), 32'(2 * (STARVE + 1)));
    @(negedge clk);
    i_req = 1'b0; d_read = 1'b0; mem_ack = 1'b0;
    @(negedge clk);

    mem_xact(1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_0001, 3, 1'b0);
    io_xact(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0000_00FF);
    mem_xact(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 1'b1);
    fetch_io(32'hFFFF_FFFF);
    mem_xact(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 1'b0);

    // Reset lands in the third MEM_I cycle (after two wait states)
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h400; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_pre_read", 32'(mem_read), 1);
    chk("midrst_pre_done", 32'(i_done), 0);
    rst = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk);
    i_req = 1'b0;
    #1 chk_zero("midrst_hold");
    rst = 1'b0;
    mem_xact(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 4));
      ma   = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      ia   = IO_BASE + 32'($urandom_range(0, 15));
      ack  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      case (kind)
        0: mem_xact(1'b0, 1'b0, ma, 32'h0, ack, 1'b0);
        1: mem_xact(1'b0, 1'b1, ma, $urandom, ack, 1'b0);
        2: io_xact(1'($urandom_range(0, 1)), ia, $urandom, $urandom);
        3: mem_xact(1'b1, 1'b0, ma, 32'h0, ack, 1'b0);
        default: fetch_io(ia);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single-ported instruction/data memory between the fetch unit and the load/store unit, and routes data accesses in the IO region to the memory-mapped IO block instead of memory. Sits between the rv32 core's two bus masters and the memory and IO slaves. Sequences each access through a small FSM with a wait-state handshake, a bus timeout and a fetch anti-starvation counter.

## Interface
- TIMEOUT, 16: max cycles a memory access waits for mem_ack before abort.
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending.
- IO_BASE, 32'hFFFF_FFF0: addresses >= IO_BASE are the IO region.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request, held until i_done.
- i_addr  in  32  fetch address, stable while i_req.
- i_rdata  out  32  fetch data, valid only with i_done.
- i_done  out  1  one-cycle fetch completion.
- i_err  out  1  qualifies i_done: timeout or fetch from IO region.
- d_read, d_write  in  1  data request, held until d_done; both high is treated as write.
- d_addr, d_wdata  in  32  data address / write data, stable while requesting.
- d_rdata  out  32  load data, valid only with d_done.
- d_done  out  1  one-cycle data completion.
- d_err  out  1  qualifies d_done: timeout.
- mem_addr, mem_wdata  out  32  registered memory address / write data.
- mem_read, mem_write  out  1  memory strobes, held until ack or timeout.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- io_addr, io_wdata  out  32  IO address / write data.
- io_read, io_write  out  1  one-cycle IO strobes.
- io_rdata  in  32  IO read data, sampled in the io_read cycle.

## Operation
- States: IDLE, MEM_D, MEM_I, IO_D, ERR_I.
- IDLE: arbitrate; at most one grant per cycle. Data wins unless starve_cnt == STARVE_LIMIT and i_req is high, in which case fetch wins.
- Data grant: if d_addr >= IO_BASE go to IO_D, else MEM_D. Fetch grant: if i_addr >= IO_BASE go to ERR_I, else MEM_I. On grant, register address, write data and direction into mem_*/io_*.
- starve_cnt: +1 (saturating) on each data grant while i_req is high. Cleared on a fetch grant or on any cycle with i_req low.
- MEM_D/MEM_I: mem_read or mem_write held high. On mem_ack: done pulses the same cycle, rdata = mem_rdata, back to IDLE.
- Timeout: the wait counter increments each cycle without ack. On the cycle it reaches TIMEOUT-1: done pulses with err=1, rdata=0, strobes drop, back to IDLE. A later stray mem_ack in IDLE is ignored.
- IO_D: exactly one cycle. io_read/io_write high, d_done=1, d_rdata=io_rdata on reads. Back to IDLE.
- ERR_I: one cycle. i_done=1, i_err=1, i_rdata=0, no memory access.
- Requesters drop or change their request the cycle after done. The FSM is in IDLE that cycle, so no double grant occurs.

## Timing
- Reset (async): state IDLE, all strobes, done, err, counters 0; all data/address outputs 0. A transaction in flight is abandoned with no done.
- Memory access: grant cycle in IDLE, then MEM_x. Zero-wait ack completes in the 2nd cycle, giving 2-cycle throughput per requester. Each wait state adds 1 cycle.
- IO access: 2 cycles (IDLE grant, IO_D with done).
- done/err/rdata are combinational from state and mem_ack; strobes and addresses are registered.
- Simultaneous i_req and data request in IDLE: data granted; fetch waits in IDLE for the next decision.
- Requests arriving during MEM_x/IO_D are not sampled until IDLE.

## Structure
- bus_pkg: state enum bus_state_t, IO_BASE default, request-type enum (RD/WR/FETCH).
- Sub-module bus_timeout_ctr: clear/enable counter with a terminal-count output at TIMEOUT-1.
- Arbitration, address decode and strobe registers stay in mem_bus_arbiter.

## Test plan
- Data write to 32'h0000_0100 with data 32'hA5A5_0001, ack on the 3rd MEM_D cycle -> mem_write high for 3 cycles, mem_wdata=32'hA5A5_0001, d_done on the ack cycle, d_err=0.
- i_req and d_read both high from reset release, zero-wait memory, data re-requested continuously -> 4 data grants, then a fetch grant, then data again. i_done appears within 10 cycles.
- d_read at 32'hFFFF_FFFC with io_rdata=32'h0000_00FF -> io_read pulses 1 cycle, d_rdata=32'h0000_00FF with d_done, mem_read never asserted.
- d_read at 32'h0000_0040, mem_ack never asserted, TIMEOUT=16 -> mem_read high 16 cycles, d_done with d_err=1 and d_rdata=0, state back to IDLE. An ack 2 cycles later is ignored.
- i_req at 32'hFFFF_FFFF -> i_done and i_err in cycle 2, no mem_* or io_* strobe.
- rst asserted mid-MEM_I (wait state 2) -> all outputs 0 in the same cycle, no i_done. A new i_req after release completes normally.
